// File: rtl/uart_baud_gen_if.sv
// ==========================================================================
// uart_baud_gen_if : control/tick bundle between a UART engine and its baud generator
// Rev 1.0
// ==========================================================================
`default_nettype none

interface uart_baud_gen_if #(
  parameter int DIV_WIDTH   = 16,
  parameter int FRAC_WIDTH  = 4,
  parameter int PHASE_WIDTH = 4
);
  logic                   enable;
  logic                   div_load;
  logic [DIV_WIDTH-1:0]   div_int;
  logic [FRAC_WIDTH-1:0]  div_frac;
  logic                   sync_clear;
  logic                   os_tick;
  logic                   bit_tick;
  logic [PHASE_WIDTH-1:0] phase;
  logic                   div_pending;

  modport master (
    output enable, div_load, div_int, div_frac, sync_clear,
    input  os_tick, bit_tick, phase, div_pending
  );

  modport slave (
    input  enable, div_load, div_int, div_frac, sync_clear,
    output os_tick, bit_tick, phase, div_pending
  );
endinterface

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ==========================================================================
// uart_baud_gen : fractional-divisor oversample/bit tick generator; UART_BAUD_SIM_FAST_EN forces reset divisor 6.0
// Rev 1.0
// ==========================================================================
`default_nettype none

module uart_baud_gen #(
  parameter int C_SYSTEM_FREQ = 100_000_000,
  parameter int C_BAUDRATE    = 115_200,
  parameter int OVERSAMPLE    = 16,
  parameter int DIV_WIDTH     = 16,
  parameter int FRAC_WIDTH    = 4
) (
  input  wire logic       Clk,
  input  wire logic       Resetn,
  uart_baud_gen_if.slave  bus
);

  localparam int PHASE_WIDTH = $clog2(OVERSAMPLE);

`ifdef UART_BAUD_SIM_FAST_EN
  localparam logic [DIV_WIDTH-1:0]  DEF_INT  = DIV_WIDTH'(6);
  localparam logic [FRAC_WIDTH-1:0] DEF_FRAC = '0;
`else
  localparam logic [63:0] OS_RATE = 64'(C_BAUDRATE) * 64'(OVERSAMPLE);
  localparam logic [63:0] DEF_FX  = (64'(C_SYSTEM_FREQ) * (64'd1 << FRAC_WIDTH) + OS_RATE / 64'd2) / OS_RATE;
  localparam logic [DIV_WIDTH-1:0]  DEF_INT  = DEF_FX[FRAC_WIDTH +: DIV_WIDTH];
  localparam logic [FRAC_WIDTH-1:0] DEF_FRAC = DEF_FX[FRAC_WIDTH-1:0];
`endif

  logic [DIV_WIDTH-1:0]   cnt;
  logic [DIV_WIDTH-1:0]   int_act;
  logic [DIV_WIDTH-1:0]   int_sh;
  logic [FRAC_WIDTH-1:0]  frac_act;
  logic [FRAC_WIDTH-1:0]  frac_sh;
  logic [FRAC_WIDTH-1:0]  acc;
  logic                   stretch;
  logic                   os_tick_q;
  logic                   bit_tick_q;
  logic                   pending;
  logic [PHASE_WIDTH-1:0] phase_q;

  logic [DIV_WIDTH:0]     period_m1;
  logic                   at_end;
  logic [FRAC_WIDTH:0]    acc_sum;
  logic [DIV_WIDTH-1:0]   load_int;
  logic [FRAC_WIDTH-1:0]  load_frac;

  // Period is evaluated one bit wider so a full-scale int plus stretch cannot wrap.
  always_comb begin
    period_m1 = {1'b0, int_act} + (DIV_WIDTH+1)'(stretch) - (DIV_WIDTH+1)'(1);
    at_end    = ({1'b0, cnt} == period_m1);
    acc_sum   = {1'b0, acc} + {1'b0, frac_act};
    load_int  = bus.div_int;
    load_frac = bus.div_frac;
    if (bus.div_int < DIV_WIDTH'(2)) begin
      load_int  = DIV_WIDTH'(2);
      load_frac = '0;
    end
  end

  // Shadow swaps in on the cycle after a tick, so the running period is never cut short.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      int_act  <= DEF_INT;
      frac_act <= DEF_FRAC;
      int_sh   <= DEF_INT;
      frac_sh  <= DEF_FRAC;
      pending  <= 1'b0;
    end else if (bus.div_load) begin
      int_sh  <= load_int;
      frac_sh <= load_frac;
      if (!bus.enable) begin
        int_act  <= load_int;
        frac_act <= load_frac;
        pending  <= 1'b0;
      end else begin
        pending  <= 1'b1;
      end
    end else if (pending && (os_tick_q || !bus.enable)) begin
      int_act  <= int_sh;
      frac_act <= frac_sh;
      pending  <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      cnt        <= '0;
      acc        <= '0;
      stretch    <= 1'b0;
      phase_q    <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else if (!bus.enable || bus.sync_clear) begin
      cnt        <= '0;
      acc        <= '0;
      stretch    <= 1'b0;
      phase_q    <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else if (at_end) begin
      cnt              <= '0;
      {stretch, acc}   <= acc_sum;
      phase_q          <= phase_q + PHASE_WIDTH'(1);
      os_tick_q        <= 1'b1;
      bit_tick_q       <= (phase_q == PHASE_WIDTH'(OVERSAMPLE - 1));
    end else begin
      cnt        <= cnt + DIV_WIDTH'(1);
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end
  end

  assign bus.os_tick     = os_tick_q;
  assign bus.bit_tick    = bit_tick_q;
  assign bus.phase       = phase_q;
  assign bus.div_pending = pending;

endmodule

`default_nettype wire
